// File: rtl/alu_multicycle.sv
// Handshaked ALU: single-cycle ops answer one cycle after acceptance, while
// mul/divu/remu iterate one bit per cycle for WIDTH cycles.
module alu_multicycle #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] alu_op1,
    input  logic [WIDTH-1:0] alu_op2,
    input  logic [3:0]       alu_ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_res,
    output logic             OF
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_EQ   = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_SLT  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_MUL  = 4'b1011;
    localparam logic [3:0] OP_DIVU = 4'b1100;
    localparam logic [3:0] OP_REMU = 4'b1101;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state_reg;
    logic [SHW-1:0]     cnt_reg;
    logic [WIDTH-1:0]   op1_reg;
    logic [WIDTH-1:0]   op2_reg;
    logic [3:0]         ctrl_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0]   rem_reg;
    logic [WIDTH-1:0]   quot_reg;
    logic [WIDTH-1:0]   res_reg;
    logic               of_reg;

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign alu_res   = res_reg;
    assign OF        = of_reg;

    // Single-cycle results are computed straight from the port operands.
    logic [WIDTH-1:0] sc_res;
    logic             sc_of;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [SHW-1:0]   sh;
    logic             is_long;

    assign sum     = alu_op1 + alu_op2;
    assign diff    = alu_op1 - alu_op2;
    assign sh      = alu_op2[SHW-1:0];
    assign is_long = (alu_ctrl == OP_MUL) || (alu_ctrl == OP_DIVU) || (alu_ctrl == OP_REMU);

    always_comb begin
        sc_res = '0;
        sc_of  = 1'b0;
        case (alu_ctrl)
            OP_ADD: begin
                sc_res = sum;
                sc_of  = (alu_op1[WIDTH-1] == alu_op2[WIDTH-1]) && (sum[WIDTH-1] != alu_op1[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res = diff;
                sc_of  = (alu_op1[WIDTH-1] != alu_op2[WIDTH-1]) && (diff[WIDTH-1] != alu_op1[WIDTH-1]);
            end
            OP_EQ:   sc_res = {{(WIDTH-1){1'b0}}, alu_op1 == alu_op2};
            OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, alu_op1 < alu_op2};
            OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, $signed(alu_op1) < $signed(alu_op2)};
            OP_AND:  sc_res = alu_op1 & alu_op2;
            OP_OR:   sc_res = alu_op1 | alu_op2;
            OP_XOR:  sc_res = alu_op1 ^ alu_op2;
            OP_SRL:  sc_res = alu_op1 >> sh;
            OP_SLL:  sc_res = alu_op1 << sh;
            OP_SRA:  sc_res = $unsigned($signed(alu_op1) >>> sh);
            default: begin
                sc_res = '0;
                sc_of  = 1'b0;
            end
        endcase
    end

    // Shift-add multiply: upper half accumulates, lower half shifts out multiplier bits.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] acc_next;
    assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, (acc_reg[0] ? op1_reg : {WIDTH{1'b0}})};
    assign acc_next = {mul_sum, acc_reg[WIDTH-1:1]};

    // Restoring division; a zero divisor naturally yields all-ones quotient and remainder = dividend.
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_sub;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quot_next;
    assign div_shift = {rem_reg, quot_reg[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, op2_reg});
    assign div_sub   = div_shift[WIDTH-1:0] - op2_reg;
    assign rem_next  = div_ge ? div_sub : div_shift[WIDTH-1:0];
    assign quot_next = {quot_reg[WIDTH-2:0], div_ge};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            op1_reg   <= '0;
            op2_reg   <= '0;
            ctrl_reg  <= '0;
            acc_reg   <= '0;
            rem_reg   <= '0;
            quot_reg  <= '0;
            res_reg   <= '0;
            of_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        op1_reg  <= alu_op1;
                        op2_reg  <= alu_op2;
                        ctrl_reg <= alu_ctrl;
                        cnt_reg  <= '0;
                        acc_reg  <= {{WIDTH{1'b0}}, alu_op2};
                        rem_reg  <= '0;
                        quot_reg <= alu_op1;
                        if (is_long) begin
                            state_reg <= BUSY;
                        end else begin
                            res_reg   <= sc_res;
                            of_reg    <= sc_of;
                            state_reg <= DONE;
                        end
                    end
                end
                BUSY: begin
                    acc_reg  <= acc_next;
                    rem_reg  <= rem_next;
                    quot_reg <= quot_next;
                    cnt_reg  <= cnt_reg + SHW'(1);
                    if (cnt_reg == {SHW{1'b1}}) begin
                        state_reg <= DONE;
                        case (ctrl_reg)
                            OP_MUL: begin
                                res_reg <= acc_next[WIDTH-1:0];
                                of_reg  <= |acc_next[2*WIDTH-1:WIDTH];
                            end
                            OP_DIVU: begin
                                res_reg <= quot_next;
                                of_reg  <= (op2_reg == '0);
                            end
                            default: begin
                                res_reg <= rem_next;
                                of_reg  <= (op2_reg == '0);
                            end
                        endcase
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_multicycle.sv
// Directed and random checks of alu_multicycle against an arithmetic reference model.
module tb_alu_multicycle;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic [3:0]  alu_ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_res;
    logic        OF;

    int checks   = 0;
    int failures = 0;

    alu_multicycle #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_ctrl(alu_ctrl),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_res(alu_res), .OF(OF)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the operation's definition.
    function automatic void model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic o);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint s;
        logic [63:0] p;
        int n = int'(b % 32);
        r = 32'h0;
        o = 1'b0;
        case (c)
            4'd0: begin s = sa + sb; r = s[31:0]; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'd1: begin s = sa - sb; r = s[31:0]; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'd2: r = (a == b) ? 32'd1 : 32'd0;
            4'd3: r = (a < b) ? 32'd1 : 32'd0;
            4'd4: r = (sa < sb) ? 32'd1 : 32'd0;
            4'd5: r = a & b;
            4'd6: r = a | b;
            4'd7: r = a ^ b;
            4'd8: r = a >> n;
            4'd9: r = a << n;
            4'd10: begin s = sa >>> n; r = s[31:0]; end
            4'd11: begin p = {32'h0, a} * {32'h0, b}; r = p[31:0]; o = (p[63:32] != 32'h0); end
            4'd12: begin r = (b == 0) ? 32'hFFFF_FFFF : a / b; o = (b == 0); end
            4'd13: begin r = (b == 0) ? a : a % b; o = (b == 0); end
            default: begin r = 32'h0; o = 1'b0; end
        endcase
    endfunction

    // Issue one request, wait for the result, check latency/value/flag, then drain it.
    task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [31:0] er;
        logic        eo;
        int          lat;
        int          exp_lat;
        logic        ready_leak;
        model(c, a, b, er, eo);
        exp_lat = (c == 4'd11 || c == 4'd12 || c == 4'd13) ? 33 : 1;
        @(negedge clk);
        chk({tag, "_in_ready"}, {63'h0, in_ready}, 64'h1);
        in_valid = 1'b1;
        alu_ctrl = c;
        alu_op1  = a;
        alu_op2  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        alu_op1  = $urandom;
        alu_op2  = $urandom;
        alu_ctrl = 4'($urandom);
        lat = 0;
        ready_leak = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (in_ready !== 1'b0) ready_leak = 1'b1;
        end while (out_valid !== 1'b1 && lat < 100);
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_busy_in_ready"}, {63'h0, ready_leak}, 64'h0);
        chk({tag, "_res"}, {32'h0, alu_res}, {32'h0, er});
        chk({tag, "_of"}, {63'h0, OF}, {63'h0, eo});
        $display("op=%0d a=%08h b=%08h res=%08h of=%0b lat=%0d", c, a, b, alu_res, OF, lat);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_drained"}, {62'h0, out_valid, in_ready}, 64'h1);
    endtask

    initial begin
        logic [31:0] held_res;
        logic        held_of;
        logic [3:0]  rc;
        logic [31:0] ra;
        logic [31:0] rb;
        int          stale;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        alu_op1 = '0; alu_op2 = '0; alu_ctrl = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", {63'h0, out_valid}, 64'h0);
        chk("reset_in_ready", {63'h0, in_ready}, 64'h1);
        chk("reset_res", {32'h0, alu_res}, 64'h0);
        chk("reset_of", {63'h0, OF}, 64'h0);

        run_op(4'd0, 32'h7FFF_FFFF, 32'h0000_0001, "add_ovf");
        run_op(4'd1, 32'h8000_0000, 32'h0000_0001, "sub_ovf");
        run_op(4'd11, 32'h0001_0000, 32'h0001_0000, "mul_ovf");
        run_op(4'd11, 32'd12345, 32'd6789, "mul_small");
        run_op(4'd12, 32'd100, 32'd7, "divu");
        run_op(4'd13, 32'd100, 32'd7, "remu");
        run_op(4'd12, 32'd5, 32'd0, "divu_zero");
        run_op(4'd13, 32'd5, 32'd0, "remu_zero");
        run_op(4'd10, 32'h8000_0000, 32'h0000_0024, "sra");
        run_op(4'd8, 32'h8000_0000, 32'h0000_0024, "srl");
        run_op(4'd4, 32'hFFFF_FFFF, 32'h0000_0001, "slt");
        run_op(4'd3, 32'hFFFF_FFFF, 32'h0000_0001, "sltu");
        run_op(4'd14, 32'h1234_5678, 32'h1, "op14");
        run_op(4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "op15");

        // Backpressure: result must hold while out_ready stays low.
        @(negedge clk);
        in_valid = 1'b1; alu_ctrl = 4'd0; alu_op1 = 32'd10; alu_op2 = 32'd20;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("bp_first_valid", {63'h0, out_valid}, 64'h1);
        held_res = alu_res;
        held_of  = OF;
        chk("bp_first_res", {32'h0, alu_res}, 64'd30);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; alu_ctrl = 4'd7; alu_op1 = $urandom; alu_op2 = $urandom;
            @(negedge clk);
            chk("bp_hold_valid", {63'h0, out_valid}, 64'h1);
            chk("bp_hold_ready", {63'h0, in_ready}, 64'h0);
            chk("bp_hold_res", {31'h0, OF, alu_res}, {31'h0, held_of, held_res});
        end
        // out_ready together with in_valid: only the output side completes.
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("bp_release", {62'h0, out_valid, in_ready}, 64'h1);
        $display("backpressure res=%08h of=%0b released", held_res, held_of);

        // Reset during a divide: no result may ever surface for it.
        @(negedge clk);
        in_valid = 1'b1; alu_ctrl = 4'd12; alu_op1 = 32'd1000; alu_op2 = 32'd3;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid", {63'h0, out_valid}, 64'h0);
        chk("rst_mid_ready", {63'h0, in_ready}, 64'h1);
        chk("rst_mid_res", {31'h0, OF, alu_res}, 64'h0);
        run_op(4'd0, 32'd3, 32'd4, "add_after_rst");
        stale = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid !== 1'b0) stale++;
        end
        chk("no_stale_divu", 64'(stale), 64'h0);
        $display("reset mid-divu stale_valid_cycles=%0d", stale);

        // Randomised operations, with corner operands mixed in.
        for (int i = 0; i < 40; i++) begin
            rc = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'h0;
                1: ra = 32'h8000_0000;
                2: rb = 32'($urandom_range(0, 40));
                default: ;
            endcase
            run_op(rc, ra, rb, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
